// File: rtl/uart_tx_cfg_if.sv
// Word-push handshake into the UART transmitter's input FIFO.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_cfg_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: small input FIFO feeding a start/data/parity/stop
// serializer. tx_out is registered from the FSM state, so the line trails the state by one clock.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  uart_tx_cfg_if.slave                s_if,
  output logic                        o_tx_out,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BDW = $clog2(CLKS_PER_BIT);
  localparam int BTW = $clog2(DATA_W);

  localparam logic [CW-1:0]  FULL      = CW'(FIFO_DEPTH);
  localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLKS_PER_BIT - 1);
  localparam logic [BTW-1:0] DATA_LAST = BTW'(DATA_W - 1);
  localparam logic [BTW-1:0] STOP_LAST = BTW'(STOP_BITS - 1);
  localparam logic           ODD       = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            r_state;
  logic [BDW-1:0]    r_baud;
  logic [BTW-1:0]    r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_tx;
  logic              r_busy;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_count;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic              w_baud_end;
  logic [DATA_W-1:0] w_head;

  assign w_ready       = (r_count != FULL);
  assign s_if.tx_ready = w_ready;
  // Gating with reset keeps the storage write from firing while reset is held.
  assign w_push        = i_reset && s_if.tx_valid && w_ready;
  assign w_nonempty    = (r_count != '0);
  assign w_baud_end    = (r_baud == BAUD_LAST);
  assign w_head        = r_mem[r_rd];

  // Pop from idle, or at the very end of the last stop bit for back-to-back frames.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = w_nonempty;
      STOP:    w_pop = w_baud_end && (r_bit == STOP_LAST) && w_nonempty;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= s_if.tx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (r_state != IDLE) || w_nonempty;
      // Word and its parity are frozen here; later pushes never touch the frame in flight.
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (^w_head) ^ ODD;
      end
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) r_state <= START;
        end
        START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
              r_state <= (PARITY != 0) ? PAR : STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PAR: begin
          r_tx <= r_par;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= w_pop ? START : IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_out     = r_tx;
  assign o_busy       = r_busy;
  assign o_fifo_count = r_count;
endmodule
